rv32v_decode_execute_seq: RTL and testbench
===========================================

// Module: rv32v_decode_execute_seq
// PURPOSE
//  Buffered, lane-parametrised sequencer between vector decode and execute.
//  Queues up to DEPTH decoded vector instructions and issues each one to execute
//  as a series of element-group beats, NUM_LANES elements per beat, from vstart up to vl.
//  Each beat carries the per-lane element index and a tail-active flag.
//  Generalises the fixed two-lane decode/execute hand-off to N lanes, with valid/ready
//  back-pressure and flush.
// PARAMETERS
//  NUM_LANES  2   lanes per beat; power of two, >=1
//  DEPTH      2   instruction FIFO entries; >=1
//  CTRL_W     256 opaque decoded-control payload width (fu_type, aluop, sew, xs1, imm, ...)
//  VL_W       9   width of vl/vstart/element index (vl <= 2**VL_W-1)
// PORTS
//  CLK            in   1               clock
//  RST            in   1               asynchronous reset, active-high
//  flush          in   1               drop all queued/in-flight instructions
//  de_valid       in   1               decode presents an instruction
//  de_ready       out  1               sequencer can accept an instruction
//  de_ctrl        in   CTRL_W          decoded control payload
//  de_vl          in   VL_W            vector length for this instruction
//  de_vstart      in   VL_W            first element index
//  ex_valid       out  1               beat presented to execute
//  ex_ready       in   1               execute accepts beat
//  ex_ctrl        out  CTRL_W          head instruction payload, constant across its beats
//  ex_elem_idx    out  NUM_LANES*VL_W  lane i element index = vstart+off+i (lane 0 in LSBs)
//  ex_lane_active out  NUM_LANES       lane i index < vl
//  ex_first       out  1               first beat of instruction
//  ex_last        out  1               final beat of instruction
//  occupancy      out  $clog2(DEPTH+1) queued instructions, including the one issuing
// BEHAVIOUR
//  Reset (async, RST=1):
//   - count=0, off=0, FIFO pointers=0, payload storage=0.
//   - Outputs: ex_valid=0, ex_ctrl=0, ex_elem_idx=0, ex_lane_active=0, ex_first=0,
//     ex_last=0, occupancy=0, de_ready=1.
//   - Reset mid-instruction discards everything; no partial beats resume.
//  Enqueue:
//   - Occurs when de_valid&&de_ready. Stores {ctrl, vl, vstart} at the tail.
//   - de_ready = (count<DEPTH), registered state only; no combinational path from ex_ready.
//   - Full FIFO with a same-cycle retire still deasserts de_ready.
//  FSM:
//   - IDLE (count==0): ex_valid=0.
//   - ISSUE (count>0): ex_valid=1; all ex_* driven combinationally from the head entry and off.
//   - IDLE->ISSUE on enqueue. ISSUE->IDLE on retire of the last entry with no same-cycle enqueue.
//   - Write-to-issue latency is 1 cycle: an instruction enqueued into an empty FIFO gives
//     ex_valid in the next cycle.
//  Beat arithmetic (computed in VL_W+1 bits, so there is no wrap):
//   - base = head.vstart + off.
//   - ex_elem_idx[i] = base+i, truncated to VL_W.
//   - ex_lane_active[i] = (base+i < head.vl).
//   - ex_first = (off==0).
//   - ex_last = (base+NUM_LANES >= head.vl).
//  Degenerate case: vl==0 or vstart>=vl gives exactly one beat, with lane_active all 0 and
//  first=last=1. This beat is still delivered because vsetvl/scalar-result ops must reach execute.
//  Beat accept (ex_valid&&ex_ready):
//   - Not last: off += NUM_LANES.
//   - Last: off=0 and head pops (retire).
//   - ex_ready low holds every ex_* output stable.
//  Simultaneous enqueue and retire: count is unchanged; both pointers advance.
//  flush:
//   - Synchronous and takes priority over enqueue and retire in the same cycle.
//   - Next cycle: count=0, off=0, pointers=0, ex_valid=0.
//   - The enqueue in the flush cycle is dropped.
//  Pointers wrap modulo DEPTH, and DEPTH need not be a power of two.
// STRUCTURE
//  rv32v_types_pkg:
//   - Add localparams RV32V_NUM_LANES and RV32V_SEQ_DEPTH.
//   - Add a function lane_active(base, lane, vl).
//   - Reuse VL_WIDTH for VL_W.
//  Sub-module rv32v_seq_fifo #(WIDTH, DEPTH):
//   - Generic synchronous FIFO providing count, full, empty, head, push, pop, flush.
//   - The sequencer holds only off and the beat logic around it.
// TESTING
//  1. NUM_LANES=2; vl=5, vstart=0, ex_ready=1
//     -> 3 beats with idx {0,1},{2,3},{4,5}; active 11,11,01; first on beat 1, last on beat 3.
//  2. vl=8, vstart=3, NUM_LANES=4
//     -> 2 beats with idx 3-6 then 7-10; active 1111 then 0001.
//  3. vl=0
//     -> 1 beat with active=00 and first=last=1; ex_ctrl equals de_ctrl.
//  4. DEPTH=2; 3 back-to-back instrs (vl=4 each); ex_ready held 0 for 5 cycles
//     -> de_ready=0 after 2 enqueues, beats frozen; release gives in-order drain, 2 beats each.
//  5. flush asserted on beat 2 of a vl=6 instr while a second instr queues in the same cycle
//     -> next cycle ex_valid=0, occupancy=0; the next instr restarts with ex_first=1.
//  6. RST pulse mid-beat -> all outputs at reset values immediately (async); de_ready=1.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared vector types for the decode/execute sequencer: widths, defaults,
// the sequencer FSM state encoding and a lane-activity helper.
package rv32v_types_pkg;

    localparam int VL_WIDTH        = 9;
    localparam int CTRL_WIDTH      = 256;
    localparam int RV32V_NUM_LANES = 2;
    localparam int RV32V_SEQ_DEPTH = 2;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_e;

    // Operands are widened to 32 bits so base+lane can never wrap before the compare.
    function automatic logic lane_active(input logic [31:0] base,
                                         input logic [31:0] lane,
                                         input logic [31:0] vl);
        return (base + lane) < vl;
    endfunction

endpackage

// File: rtl/rv32v_decode_execute_seq_if.sv
// Decode-side and execute-side handshake bundle of the vector sequencer.
interface rv32v_decode_execute_seq_if
    import rv32v_types_pkg::*;
#(
    parameter int NUM_LANES = RV32V_NUM_LANES,
    parameter int CTRL_W    = CTRL_WIDTH,
    parameter int VL_W      = VL_WIDTH
);

    // Both channels are valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both 1; once valid is raised the payload holds
    // steady until that transfer, and ready never depends combinationally on valid.
    logic                        de_valid;
    logic                        de_ready;
    logic [CTRL_W-1:0]           de_ctrl;
    logic [VL_W-1:0]             de_vl;
    logic [VL_W-1:0]             de_vstart;

    logic                        ex_valid;
    logic                        ex_ready;
    logic [CTRL_W-1:0]           ex_ctrl;
    logic [NUM_LANES*VL_W-1:0]   ex_elem_idx;
    logic [NUM_LANES-1:0]        ex_lane_active;
    logic                        ex_first;
    logic                        ex_last;

    modport master (
        output de_valid, de_ctrl, de_vl, de_vstart, ex_ready,
        input  de_ready, ex_valid, ex_ctrl, ex_elem_idx, ex_lane_active, ex_first, ex_last
    );

    modport slave (
        input  de_valid, de_ctrl, de_vl, de_vstart, ex_ready,
        output de_ready, ex_valid, ex_ctrl, ex_elem_idx, ex_lane_active, ex_first, ex_last
    );

endinterface

// File: rtl/rv32v_seq_fifo.sv
// Generic synchronous FIFO with flush; pointers wrap modulo DEPTH so any DEPTH >= 1 works.
module rv32v_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rv32v_decode_execute_seq.sv
// Vector decode->execute sequencer: queues decoded instructions and issues each
// as NUM_LANES-wide element beats from vstart up to vl.
module rv32v_decode_execute_seq
    import rv32v_types_pkg::*;
#(
    parameter int NUM_LANES = RV32V_NUM_LANES,
    parameter int DEPTH     = RV32V_SEQ_DEPTH,
    parameter int CTRL_W    = CTRL_WIDTH,
    parameter int VL_W      = VL_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    rv32v_decode_execute_seq_if.slave  bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output seq_state_e                 state_o
);

    localparam int ENTRY_W = CTRL_W + 2*VL_W;
    localparam int OFF_W   = VL_W + 1;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic [ENTRY_W-1:0] head;
    logic [CTRL_W-1:0]  head_ctrl;
    logic [VL_W-1:0]    head_vl, head_vstart;
    logic [CNT_W-1:0]   count;
    logic               fifo_full, fifo_empty;
    logic               push, pop, accept, beat_last;
    logic [OFF_W-1:0]   off_q, off_d, base;
    seq_state_e         state_q, state_d;

    rv32v_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  ({bus.de_ctrl, bus.de_vl, bus.de_vstart}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_ctrl, head_vl, head_vstart} = head;

    // de_ready comes only from registered occupancy, so a retire cannot open a full FIFO early.
    assign bus.de_ready = !fifo_full;
    assign push         = bus.de_valid && !fifo_full;

    // One extra bit keeps base and base+NUM_LANES from wrapping near the top of the vl range.
    assign base      = {1'b0, head_vstart} + off_q;
    assign beat_last = (base + OFF_W'(NUM_LANES)) >= {1'b0, head_vl};
    assign accept    = (state_q == SEQ_ISSUE) && bus.ex_ready && !flush_i;
    assign pop       = accept && beat_last;

    assign occupancy_o = count;
    assign state_o     = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        if (flush_i) begin
            state_d = SEQ_IDLE;
            off_d   = '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (push) state_d = SEQ_ISSUE;
                end
                SEQ_ISSUE: begin
                    if (accept) begin
                        if (beat_last) begin
                            off_d = '0;
                            if (count == CNT_W'(1) && !push) state_d = SEQ_IDLE;
                        end else begin
                            off_d = off_q + OFF_W'(NUM_LANES);
                        end
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    // Beat outputs are forced to zero while idle so stale head storage never leaks out.
    always_comb begin
        bus.ex_valid       = 1'b0;
        bus.ex_ctrl        = '0;
        bus.ex_elem_idx    = '0;
        bus.ex_lane_active = '0;
        bus.ex_first       = 1'b0;
        bus.ex_last        = 1'b0;
        if (state_q == SEQ_ISSUE) begin
            bus.ex_valid = 1'b1;
            bus.ex_ctrl  = head_ctrl;
            bus.ex_first = (off_q == '0);
            bus.ex_last  = beat_last;
            for (int i = 0; i < NUM_LANES; i++) begin
                bus.ex_elem_idx[i*VL_W +: VL_W] = VL_W'(base + OFF_W'(i));
                bus.ex_lane_active[i]           = lane_active(32'(base), 32'(i), 32'(head_vl));
            end
        end
    end

endmodule

// File: tb/tb_rv32v_decode_execute_seq.sv
// Scoreboard bench for the vector sequencer: a 2-lane and a 4-lane instance
// driven with directed instructions, beats checked by per-instance monitors.
module tb_rv32v_decode_execute_seq;
    import rv32v_types_pkg::*;

    localparam int VW   = VL_WIDTH;
    localparam int CW   = CTRL_WIDTH;
    localparam int NLA  = 2;
    localparam int NLB  = 4;
    localparam int DEP  = 2;
    localparam int EA_W = CW + NLA*VW + NLA + 2;
    localparam int EB_W = CW + NLB*VW + NLB + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic [$clog2(DEP+1)-1:0] occ_a, occ_b;
    seq_state_e st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EA_W-1:0] exp_a_q[$];
    logic [EB_W-1:0] exp_b_q[$];
    logic [EA_W-1:0] act_a, exp_a;
    logic [EB_W-1:0] act_b, exp_b;

    rv32v_decode_execute_seq_if #(.NUM_LANES(NLA), .CTRL_W(CW), .VL_W(VW)) a_if ();
    rv32v_decode_execute_seq_if #(.NUM_LANES(NLB), .CTRL_W(CW), .VL_W(VW)) b_if ();

    rv32v_decode_execute_seq #(.NUM_LANES(NLA), .DEPTH(DEP), .CTRL_W(CW), .VL_W(VW)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush_a),
        .bus         (a_if.slave),
        .occupancy_o (occ_a),
        .state_o     (st_a)
    );

    rv32v_decode_execute_seq #(.NUM_LANES(NLB), .DEPTH(DEP), .CTRL_W(CW), .VL_W(VW)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush_b),
        .bus         (b_if.slave),
        .occupancy_o (occ_b),
        .state_o     (st_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] tag, input int i0, input int i1,
                          input logic [1:0] act, input logic f, input logic l);
        exp_a_q.push_back({CW'(tag), VW'(i1), VW'(i0), act, f, l});
    endtask

    task automatic push_b(input logic [31:0] tag, input int i0, input int i1, input int i2,
                          input int i3, input logic [3:0] act, input logic f, input logic l);
        exp_b_q.push_back({CW'(tag), VW'(i3), VW'(i2), VW'(i1), VW'(i0), act, f, l});
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && !flush_a && a_if.ex_valid && a_if.ex_ready) begin
            act_a = {a_if.ex_ctrl, a_if.ex_elem_idx, a_if.ex_lane_active, a_if.ex_first, a_if.ex_last};
            n_checks++;
            if (exp_a_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_a: unexpected beat %0h, no beat expected", act_a);
            end else begin
                exp_a = exp_a_q.pop_front();
                if (act_a !== exp_a) begin
                    n_fail++;
                    $display("FAIL beat_a: got %0h, expected %0h", act_a, exp_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush_b && b_if.ex_valid && b_if.ex_ready) begin
            act_b = {b_if.ex_ctrl, b_if.ex_elem_idx, b_if.ex_lane_active, b_if.ex_first, b_if.ex_last};
            n_checks++;
            if (exp_b_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_b: unexpected beat %0h, no beat expected", act_b);
            end else begin
                exp_b = exp_b_q.pop_front();
                if (act_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL beat_b: got %0h, expected %0h", act_b, exp_b);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic enq_a(input logic [31:0] tag, input int vl, input int vs);
        int t;
        a_if.de_ctrl   = CW'(tag);
        a_if.de_vl     = VW'(vl);
        a_if.de_vstart = VW'(vs);
        a_if.de_valid  = 1'b1;
        t = 0;
        while (!a_if.de_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("enq_a_ready", a_if.de_ready, 1);
        @(posedge clk); #1;
        a_if.de_valid = 1'b0;
    endtask

    task automatic enq_b(input logic [31:0] tag, input int vl, input int vs);
        int t;
        b_if.de_ctrl   = CW'(tag);
        b_if.de_vl     = VW'(vl);
        b_if.de_vstart = VW'(vs);
        b_if.de_valid  = 1'b1;
        t = 0;
        while (!b_if.de_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("enq_b_ready", b_if.de_ready, 1);
        @(posedge clk); #1;
        b_if.de_valid = 1'b0;
    endtask

    task automatic drain_a(input string name);
        int t;
        t = 0;
        while (exp_a_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({name, "_drained"}, 64'(exp_a_q.size()), 0);
        chk({name, "_valid_after"}, a_if.ex_valid, 0);
        chk({name, "_occ_after"}, occ_a, 0);
    endtask

    task automatic drain_b(input string name);
        int t;
        t = 0;
        while (exp_b_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({name, "_drained"}, 64'(exp_b_q.size()), 0);
        chk({name, "_valid_after"}, b_if.ex_valid, 0);
        chk({name, "_occ_after"}, occ_b, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        a_if.de_valid = 1'b0; a_if.de_ctrl = '0; a_if.de_vl = '0; a_if.de_vstart = '0; a_if.ex_ready = 1'b0;
        b_if.de_valid = 1'b0; b_if.de_ctrl = '0; b_if.de_vl = '0; b_if.de_vstart = '0; b_if.ex_ready = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_ex_valid", a_if.ex_valid, 0);
        chk("rst_de_ready", a_if.de_ready, 1);
        chk("rst_occ", occ_a, 0);
        chk("rst_first_last", {a_if.ex_first, a_if.ex_last}, 0);
        chk("rst_idx", a_if.ex_elem_idx, 0);
        chk("rst_active", a_if.ex_lane_active, 0);
        chk("rst_ctrl", 64'(|a_if.ex_ctrl), 0);
        chk("rst_b_valid", b_if.ex_valid, 0);
        chk("rst_b_state", st_b, SEQ_IDLE);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: vl=5, vstart=0, two lanes, execute always ready
        a_if.ex_ready = 1'b1;
        push_a(32'h11, 0, 1, 2'b11, 1'b1, 1'b0);
        push_a(32'h11, 2, 3, 2'b11, 1'b0, 1'b0);
        push_a(32'h11, 4, 5, 2'b01, 1'b0, 1'b1);
        enq_a(32'h11, 5, 0);
        chk("t1_latency_valid", a_if.ex_valid, 1);
        chk("t1_first", a_if.ex_first, 1);
        chk("t1_state", st_a, SEQ_ISSUE);
        drain_a("t1");

        // 2: vl=8, vstart=3 on the four-lane instance
        b_if.ex_ready = 1'b1;
        push_b(32'h22, 3, 4, 5, 6,  4'b1111, 1'b1, 1'b0);
        push_b(32'h22, 7, 8, 9, 10, 4'b0001, 1'b0, 1'b1);
        enq_b(32'h22, 8, 3);
        drain_b("t2");

        // 3: vl=0, vstart>=vl, and an unaligned vstart, issued back to back
        push_a(32'hABCD, 0, 1, 2'b00, 1'b1, 1'b1);
        push_a(32'h33,   5, 6, 2'b00, 1'b1, 1'b1);
        push_a(32'h34,   1, 2, 2'b11, 1'b1, 1'b0);
        push_a(32'h34,   3, 4, 2'b01, 1'b0, 1'b1);
        enq_a(32'hABCD, 0, 0);
        enq_a(32'h33, 3, 5);
        enq_a(32'h34, 4, 1);
        drain_a("t3");

        // 4: three back-to-back instructions with execute stalled for 5 cycles
        a_if.ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_a(32'h41 + k, 0, 1, 2'b11, 1'b1, 1'b0);
            push_a(32'h41 + k, 2, 3, 2'b11, 1'b0, 1'b1);
        end
        a_if.de_ctrl = CW'(32'h41); a_if.de_vl = VW'(4); a_if.de_vstart = '0; a_if.de_valid = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_1st", a_if.ex_valid, 1);
        a_if.de_ctrl = CW'(32'h42);
        @(posedge clk); #1;
        a_if.de_ctrl = CW'(32'h43);
        chk("t4_de_ready_full", a_if.de_ready, 0);
        chk("t4_occ_full", occ_a, 2);
        repeat (5) begin
            @(posedge clk); #1;
            chk("t4_hold_idx", a_if.ex_elem_idx, 64'h200);
            chk("t4_hold_first", a_if.ex_first, 1);
            chk("t4_hold_ctrl", a_if.ex_ctrl[31:0], 32'h41);
            chk("t4_hold_occ", occ_a, 2);
        end
        a_if.ex_ready = 1'b1;
        t = 0;
        while (!a_if.de_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t4_de_ready_reopen", a_if.de_ready, 1);
        @(posedge clk); #1;
        a_if.de_valid = 1'b0;
        chk("t4_occ_after_refill", occ_a, 2);
        drain_a("t4");

        // 5: flush on beat 2 of a vl=6 instruction with an enqueue in the same cycle
        push_a(32'h51, 0, 1, 2'b11, 1'b1, 1'b0);
        enq_a(32'h51, 6, 0);
        @(posedge clk); #1;
        chk("t5_on_beat2", a_if.ex_elem_idx, 64'h602);
        flush_a = 1'b1;
        a_if.de_ctrl = CW'(32'h52); a_if.de_vl = VW'(2); a_if.de_vstart = '0; a_if.de_valid = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0;
        a_if.de_valid = 1'b0;
        chk("t5_valid_flushed", a_if.ex_valid, 0);
        chk("t5_occ_flushed", occ_a, 0);
        chk("t5_de_ready", a_if.de_ready, 1);
        chk("t5_state", st_a, SEQ_IDLE);
        push_a(32'h53, 0, 1, 2'b11, 1'b1, 1'b1);
        enq_a(32'h53, 2, 0);
        chk("t5_restart_first", a_if.ex_first, 1);
        chk("t5_restart_ctrl", a_if.ex_ctrl[31:0], 32'h53);
        drain_a("t5");

        // 6: asynchronous reset pulse while a beat is presented
        a_if.ex_ready = 1'b0;
        enq_a(32'h61, 8, 0);
        @(posedge clk); #3;
        chk("t6_pre_valid", a_if.ex_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", a_if.ex_valid, 0);
        chk("t6_rst_de_ready", a_if.de_ready, 1);
        chk("t6_rst_occ", occ_a, 0);
        chk("t6_rst_first", a_if.ex_first, 0);
        chk("t6_rst_idx", a_if.ex_elem_idx, 0);
        chk("t6_rst_ctrl", 64'(|a_if.ex_ctrl), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_if.ex_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_resume", a_if.ex_valid, 0);

        chk("final_q_a", 64'(exp_a_q.size()), 0);
        chk("final_q_b", 64'(exp_b_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
